// File: rtl/address_fifo_feeder.sv
// Address FIFO feeding a storage block: buffers upstream addresses and issues
// them one at a time as registered strobes, spaced by a settle cycle.
module address_fifo_feeder #(
  parameter int ADDRESSNBITS = 10,
  parameter int FIFODEPTH    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADDRESSNBITS-1:0]    inAddress,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic                       storageReady,
  output logic [ADDRESSNBITS-1:0]    address,
  output logic                       newAddress,
  output logic [$clog2(FIFODEPTH):0] fifoCount,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(FIFODEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFODEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDRESSNBITS-1:0] r_mem [FIFODEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic [ADDRESSNBITS-1:0] r_address;
  logic                    r_new_address;
  logic                    r_overflow;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_has_data;

  // Only the registered count gates issue, so a fresh push is never bypassed.
  assign w_has_data = (r_count != '0);
  assign inReady    = !reset && (r_count < DEPTH_C);
  assign w_push     = inValid && inReady;

  assign address    = r_address;
  assign newAddress = r_new_address;
  assign fifoCount  = r_count;
  assign overflow   = r_overflow;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_next = r_state;
    w_pop        = 1'b0;
    unique case (r_state)
      S_IDLE, S_WAIT: begin
        if (storageReady) begin
          if (w_has_data) begin
            w_pop        = 1'b1;
            w_state_next = S_SETTLE;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_SETTLE: w_state_next = S_WAIT;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_address     <= '0;
      r_new_address <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_new_address <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_address <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (inValid && !inReady) r_overflow <= 1'b1;
    end
  end

  // NOTE: storage array is deliberately not reset; the count and pointers
  // define which entries are valid, so stale contents are never read.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= inAddress;
  end

endmodule

// File: tb/tb_address_fifo_feeder.sv
// Randomised and directed stimulus for address_fifo_feeder, checked against a
// queue-based reference model and an in-order issue scoreboard.
module tb_address_fifo_feeder;

  localparam int AW    = 10;
  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] in_address = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          storage_ready = 1'b0;
  logic [AW-1:0] address;
  logic          new_address;
  logic [$clog2(DEPTH):0] fifo_count;
  logic          overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: buffered addresses, issue history, and the scoreboard of
  // accepted addresses awaiting their strobe.
  logic [AW-1:0] m_q[$];
  logic [AW-1:0] sb_q[$];
  bit            m_issued_prev = 0;
  bit            m_ovf = 0;
  bit            m_new = 0;
  logic [AW-1:0] m_addr = '0;
  bit            mon_en = 0;

  address_fifo_feeder #(.ADDRESSNBITS(AW), .FIFODEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .inAddress    (in_address),
    .inValid      (in_valid),
    .inReady      (in_ready),
    .storageReady (storage_ready),
    .address      (address),
    .newAddress   (new_address),
    .fifoCount    (fifo_count),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  // One cycle of stimulus, applied at the falling edge.
  task automatic step(input bit v, input logic [AW-1:0] a, input bit sr, input bit rst);
    @(negedge clock);
    in_valid      = v;
    in_address    = a;
    storage_ready = sr;
    reset         = rst;
  endtask

  // Issue rule: an address leaves when data was buffered before the edge,
  // storage is ready, and the previous edge was not itself an issue.
  always @(posedge clock) begin
    bit can_issue;
    bit accept;
    if (reset) begin
      m_q.delete();
      sb_q.delete();
      m_issued_prev = 0;
      m_ovf  = 0;
      m_new  = 0;
      m_addr = '0;
      mon_en = 1;
    end else begin
      can_issue = (m_q.size() > 0) && storage_ready && !m_issued_prev;
      accept    = in_valid && (m_q.size() < DEPTH);
      if (in_valid && !accept) m_ovf = 1;
      if (can_issue) m_addr = m_q.pop_front();
      if (accept) begin
        m_q.push_back(in_address);
        sb_q.push_back(in_address);
      end
      m_new = can_issue;
      m_issued_prev = can_issue;
    end
  end

  // Monitor: compares every cycle and pops the scoreboard on each strobe.
  initial begin
    logic [AW-1:0] exp_a;
    forever begin
      @(posedge clock);
      #2;
      if (mon_en) begin
        check("newAddress", 32'(new_address), 32'(m_new));
        check("address", 32'(address), 32'(m_addr));
        check("fifoCount", 32'(fifo_count), 32'(m_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("inReady", 32'(in_ready), 32'(!reset && (m_q.size() < DEPTH)));
        if (new_address === 1'b1) begin
          check("scoreboard_has_entry", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            exp_a = sb_q.pop_front();
            check("issue_order", 32'(address), 32'(exp_a));
          end
        end
      end
    end
  end

  initial begin
    // Reset
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);

    // Single push with storage ready
    step(1, 10'h005, 1, 0);
    repeat (4) step(0, '0, 1, 0);

    // Burst under back-pressure, then overflow
    for (int i = 1; i <= 8; i++) step(1, AW'(i), 0, 0);
    step(1, 10'h009, 0, 0);
    repeat (2) step(0, '0, 0, 0);

    // Drain in order
    repeat (18) step(0, '0, 1, 0);

    // Simultaneous push/pop from WAIT with three buffered
    for (int i = 0; i < 4; i++) step(1, AW'(10'h100 + i), 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    step(1, 10'h0AA, 1, 0);
    step(0, '0, 0, 0);

    // Storage stall after an issue
    step(0, '0, 1, 0);
    repeat (5) step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    repeat (10) step(0, '0, 1, 0);

    // Reset while in SETTLE with four buffered
    for (int i = 0; i < 5; i++) step(1, AW'(10'h200 + i), 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 1);
    repeat (6) step(0, '0, 1, 0);

    // Mixed random traffic, including occasional resets and pointer wrap
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 6, AW'($urandom_range(0, 1023)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 149) == 0);

    // Final drain
    repeat (24) step(0, '0, 1, 0);
    @(posedge clock);
    #3;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("final_fifoCount", 32'(fifo_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
